// File: rtl/freq_meter_bcd_pkg.sv
// Shared constants, conversion state encoding and the double-dabble nibble adjust
// used by the frequency meter and its BCD converter.
package freq_meter_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = 14;

  localparam logic [CNT_W-1:0] SAT_VALUE = 14'd9999;
  localparam logic [BCD_W-1:0] BCD_SAT   = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Add 3 to every nibble >= 5 so the following left shift carries into the next digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (s[4*d +: 4] >= 4'd5) r[4*d +: 4] = s[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_if.sv
// Measured-signal input and result bus of the frequency meter.
interface freq_meter_bcd_if;
  import freq_meter_pkg::*;

  logic             sig_in;
  logic [BCD_W-1:0] bcd;
  logic             valid;
  logic             ovf;
  logic             busy;

  modport master (output sig_in, input bcd, input valid, input ovf, input busy);
  modport slave  (input sig_in, output bcd, output valid, output ovf, output busy);
endinterface

// File: rtl/freq_meter_bcd_bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, CNT_W shift cycles per result.
//  state | meaning
//  IDLE  | waiting for start; start loads bin and clears the scratch
//  SHIFT | CNT_W adjust-and-shift cycles, busy=1
//  DONE  | scratch holds the BCD result, done=1 for one cycle
module bin2bcd_seq
  import freq_meter_pkg::*;
(
  input  logic             clk_50,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int SC_W = $clog2(CNT_W);

  conv_state_t             r_state;
  conv_state_t             w_next;
  logic [BCD_W-1:0]        r_scratch;
  logic [CNT_W-1:0]        r_bin;
  logic [SC_W-1:0]         r_shift_cnt;
  logic [BCD_W+CNT_W-1:0]  w_shifted;

  assign w_shifted = {dabble_adjust(r_scratch), r_bin} << 1;
  assign bcd       = r_scratch;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state     <= IDLE;
      r_scratch   <= '0;
      r_bin       <= '0;
      r_shift_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_bin       <= bin;
        r_scratch   <= '0;
        r_shift_cnt <= SC_W'(CNT_W - 1);
      end else if (r_state == SHIFT) begin
        r_scratch   <= w_shifted[BCD_W+CNT_W-1:CNT_W];
        r_bin       <= w_shifted[CNT_W-1:0];
        r_shift_cnt <= r_shift_cnt - SC_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (r_shift_cnt == '0) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gate-window edge counter for sig_in; each window's count is converted to packed BCD
// while the next window is already counting.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 50_000_000
) (
  input logic             clk_50,
  input logic             rst,
  freq_meter_bcd_if.slave bus
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic             r_sync1, r_sync2, r_sync3;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic             r_snap_sat;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;

  logic             w_edge, w_term, w_cnt_at_sat;
  logic [CNT_W-1:0] w_snap_cnt;
  logic             w_snap_sat;
  logic             w_conv_busy, w_conv_done, w_conv_idle, w_start;
  logic [BCD_W-1:0] w_conv_bcd, w_result;

  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_term       = (r_gate_cnt == '0);
  assign w_cnt_at_sat = (r_edge_cnt == SAT_VALUE);
  // An edge in the terminal cycle still belongs to the closing window.
  assign w_snap_cnt   = (w_edge && !w_cnt_at_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_snap_sat   = r_sat | (w_edge & w_cnt_at_sat);
  assign w_conv_idle  = ~w_conv_busy & ~w_conv_done;
  assign w_start      = w_term & w_conv_idle;
  assign w_result     = r_snap_sat ? BCD_SAT : w_conv_bcd;

  bin2bcd_seq u_bin2bcd (
    .clk_50 (clk_50),
    .rst    (rst),
    .start  (w_start),
    .bin    (w_snap_cnt),
    .busy   (w_conv_busy),
    .done   (w_conv_done),
    .bcd    (w_conv_bcd)
  );

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync3    <= 1'b0;
      r_gate_cnt <= GATE_LAST;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_snap_sat <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync1    <= bus.sig_in;
      r_sync2    <= r_sync1;
      r_sync3    <= r_sync2;
      r_gate_cnt <= w_term ? GATE_LAST : r_gate_cnt - GATE_W'(1);
      if (w_term) begin
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end else if (w_edge) begin
        if (w_cnt_at_sat) r_sat <= 1'b1;
        else              r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
      if (w_start) r_snap_sat <= w_snap_sat;
      if (w_conv_done) begin
        r_bcd <= w_result;
        r_ovf <= r_snap_sat;
      end
    end
  end

  // The result is visible during the valid cycle itself, then held in r_bcd/r_ovf.
  assign bus.bcd   = w_conv_done ? w_result : r_bcd;
  assign bus.ovf   = w_conv_done ? r_snap_sat : r_ovf;
  assign bus.valid = w_conv_done;
  assign bus.busy  = w_conv_busy;

  // A window closing while a conversion is still running would lose its snapshot.
  a_term_in_idle: assert property (@(posedge clk_50) disable iff (rst) w_term |-> w_conv_idle);

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd: three instances with short gate windows, cycle-exact
// stimulus on sig_in and hand-computed counts, valid timing and flags.
module tb_freq_meter_bcd;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic rst_a, rst_b, rst_c;

  freq_meter_bcd_if if_a ();
  freq_meter_bcd_if if_b ();
  freq_meter_bcd_if if_c ();

  freq_meter_bcd #(.GATE_CYCLES(100))   dut_a (.clk_50(clk_50), .rst(rst_a), .bus(if_a.slave));
  freq_meter_bcd #(.GATE_CYCLES(25000)) dut_b (.clk_50(clk_50), .rst(rst_b), .bus(if_b.slave));
  freq_meter_bcd #(.GATE_CYCLES(20000)) dut_c (.clk_50(clk_50), .rst(rst_c), .bus(if_c.slave));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_a, cyc_b, cyc_c;
  int   per_a, ph_a, per_b, ph_b, per_c, ph_c;
  logic last_busy;

  // One clock: step to #1 after the edge, count cycles, drive the square-wave generators.
  task automatic tick();
    @(posedge clk_50);
    #1;
    cyc_a++; cyc_b++; cyc_c++;
    if (per_a != 0) begin if_a.sig_in = (ph_a < per_a / 2); ph_a = (ph_a + 1 == per_a) ? 0 : ph_a + 1; end
    if (per_b != 0) begin if_b.sig_in = (ph_b < per_b / 2); ph_b = (ph_b + 1 == per_b) ? 0 : ph_b + 1; end
    if (per_c != 0) begin if_c.sig_in = (ph_c < per_c / 2); ph_c = (ph_c + 1 == per_c) ? 0 : ph_c + 1; end
  endtask

  function automatic int get_cyc(input int sel);
    case (sel) 0: return cyc_a; 1: return cyc_b; default: return cyc_c; endcase
  endfunction
  function automatic logic get_valid(input int sel);
    case (sel) 0: return if_a.valid; 1: return if_b.valid; default: return if_c.valid; endcase
  endfunction
  function automatic logic get_busy(input int sel);
    case (sel) 0: return if_a.busy; 1: return if_b.busy; default: return if_c.busy; endcase
  endfunction
  function automatic logic get_ovf(input int sel);
    case (sel) 0: return if_a.ovf; 1: return if_b.ovf; default: return if_c.ovf; endcase
  endfunction
  function automatic logic [15:0] get_bcd(input int sel);
    case (sel) 0: return if_a.bcd; 1: return if_b.bcd; default: return if_c.bcd; endcase
  endfunction

  task automatic advance(input int sel, input int target);
    while (get_cyc(sel) < target) tick();
  endtask

  task automatic wait_valid(input int sel, input int budget, output int at_cyc);
    int   n;
    logic found;
    n = 0; found = 1'b0; at_cyc = -1; last_busy = 1'b0;
    while (!found && n < budget) begin
      last_busy = get_busy(sel);
      tick();
      n++;
      if (get_valid(sel) === 1'b1) begin
        found  = 1'b1;
        at_cyc = get_cyc(sel);
      end
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL valid_timeout dut%0d: no valid pulse within %0d cycles, required one", sel, budget);
    end
  endtask

  task automatic test_reset();
    int at;
    per_a = 2; ph_a = 0;
    repeat (3) tick();
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h, expected 0000", if_a.bcd); end
    n_checks++; if (if_a.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", if_a.valid); end
    n_checks++; if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", if_a.ovf); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", if_a.busy); end
    rst_a = 1'b0; per_a = 0; if_a.sig_in = 1'b0; cyc_a = 0;
    wait_valid(0, 200, at);
    n_checks++; if (at !== 114) begin n_fail++; $display("FAIL first_valid_cycle: got %0d, expected 114", at); end
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL first_window_bcd: got %h, expected 0000", if_a.bcd); end
    n_checks++; if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL first_window_ovf: got %b, expected 0", if_a.ovf); end
  endtask

  task automatic test_period10();
    int at;
    per_a = 10; ph_a = 0;
    wait_valid(0, 200, at);
    n_checks++; if (at !== 214) begin n_fail++; $display("FAIL p10_valid_w1: got cycle %0d, expected 214", at); end
    wait_valid(0, 200, at);
    n_checks++; if (at !== 314) begin n_fail++; $display("FAIL p10_valid_w2: got cycle %0d, expected 314", at); end
    n_checks++; if (if_a.bcd !== 16'h0010) begin n_fail++; $display("FAIL p10_bcd_w2: got %h, expected 0010", if_a.bcd); end
    n_checks++; if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL p10_ovf_w2: got %b, expected 0", if_a.ovf); end
    n_checks++; if (last_busy !== 1'b1) begin n_fail++; $display("FAIL p10_busy_before_valid: got %b, expected 1", last_busy); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL p10_busy_at_valid: got %b, expected 0", if_a.busy); end
    tick();
    n_checks++; if (if_a.valid !== 1'b0) begin n_fail++; $display("FAIL p10_valid_width: got %b, expected 0", if_a.valid); end
    n_checks++; if (if_a.bcd !== 16'h0010) begin n_fail++; $display("FAIL p10_bcd_hold: got %h, expected 0010", if_a.bcd); end
    wait_valid(0, 200, at);
    n_checks++; if (at !== 414) begin n_fail++; $display("FAIL p10_valid_w3: got cycle %0d, expected 414", at); end
    n_checks++; if (if_a.bcd !== 16'h0010) begin n_fail++; $display("FAIL p10_bcd_w3: got %h, expected 0010", if_a.bcd); end
  endtask

  task automatic test_stuck_and_edge_at_t();
    int at;
    per_a = 0; if_a.sig_in = 1'b1;
    wait_valid(0, 200, at);
    n_checks++; if (at !== 514) begin n_fail++; $display("FAIL stuck_valid_w4: got cycle %0d, expected 514", at); end
    wait_valid(0, 200, at);
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL stuck_bcd_w5: got %h, expected 0000", if_a.bcd); end
    n_checks++; if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL stuck_ovf_w5: got %b, expected 0", if_a.ovf); end
    if_a.sig_in = 1'b0;
    wait_valid(0, 200, at);
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL fall_only_bcd_w6: got %h, expected 0000", if_a.bcd); end
    advance(0, 797);
    if_a.sig_in = 1'b1;
    wait_valid(0, 200, at);
    n_checks++; if (at !== 814) begin n_fail++; $display("FAIL edge_at_t_valid: got cycle %0d, expected 814", at); end
    n_checks++; if (if_a.bcd !== 16'h0001) begin n_fail++; $display("FAIL edge_at_t_bcd_w7: got %h, expected 0001", if_a.bcd); end
    wait_valid(0, 200, at);
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL after_t_bcd_w8: got %h, expected 0000", if_a.bcd); end
  endtask

  task automatic test_reset_mid_shift();
    int at;
    per_a = 10; ph_a = 0;
    advance(0, 1104);
    n_checks++; if (if_a.busy !== 1'b1) begin n_fail++; $display("FAIL midshift_busy: got %b, expected 1", if_a.busy); end
    n_checks++; if (if_a.bcd !== 16'h0008) begin n_fail++; $display("FAIL midshift_prev_bcd_w10: got %h, expected 0008", if_a.bcd); end
    rst_a = 1'b1; per_a = 0; if_a.sig_in = 1'b0;
    tick();
    rst_a = 1'b0; cyc_a = 0;
    if_a.sig_in = 1'b1; per_a = 10; ph_a = 1;
    n_checks++; if (if_a.bcd !== 16'h0000) begin n_fail++; $display("FAIL midshift_reset_bcd: got %h, expected 0000", if_a.bcd); end
    n_checks++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL midshift_reset_busy: got %b, expected 0", if_a.busy); end
    wait_valid(0, 200, at);
    n_checks++; if (at !== 114) begin n_fail++; $display("FAIL midshift_next_valid: got cycle %0d, expected 114", at); end
    n_checks++; if (if_a.bcd !== 16'h0010) begin n_fail++; $display("FAIL midshift_fresh_bcd: got %h, expected 0010", if_a.bcd); end
    n_checks++; if (if_a.ovf !== 1'b0) begin n_fail++; $display("FAIL midshift_fresh_ovf: got %b, expected 0", if_a.ovf); end
    per_a = 0;
  endtask

  task automatic test_saturation();
    int at;
    rst_b = 1'b0; cyc_b = 0; per_b = 2; ph_b = 0;
    advance(1, 24999);
    per_b = 4; ph_b = 0;
    wait_valid(1, 100, at);
    n_checks++; if (at !== 25014) begin n_fail++; $display("FAIL sat_valid_cycle: got %0d, expected 25014", at); end
    n_checks++; if (if_b.bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_bcd: got %h, expected 9999", if_b.bcd); end
    n_checks++; if (if_b.ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b, expected 1", if_b.ovf); end
    wait_valid(1, 25100, at);
    n_checks++; if (at !== 50014) begin n_fail++; $display("FAIL p4_valid_cycle: got %0d, expected 50014", at); end
    n_checks++; if (if_b.bcd !== 16'h6250) begin n_fail++; $display("FAIL p4_bcd: got %h, expected 6250", if_b.bcd); end
    n_checks++; if (if_b.ovf !== 1'b0) begin n_fail++; $display("FAIL p4_ovf: got %b, expected 0", if_b.ovf); end
    rst_b = 1'b1; per_b = 0;
  endtask

  task automatic test_exact_9999();
    int at;
    rst_c = 1'b0; cyc_c = 0; per_c = 2; ph_c = 0;
    advance(2, 19997);
    per_c = 0;
    wait_valid(2, 100, at);
    n_checks++; if (at !== 20014) begin n_fail++; $display("FAIL exact_valid_cycle: got %0d, expected 20014", at); end
    n_checks++; if (if_c.bcd !== 16'h9999) begin n_fail++; $display("FAIL exact_bcd: got %h, expected 9999", if_c.bcd); end
    n_checks++; if (if_c.ovf !== 1'b0) begin n_fail++; $display("FAIL exact_ovf: got %b, expected 0", if_c.ovf); end
    rst_c = 1'b1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.sig_in = 1'b0; if_b.sig_in = 1'b0; if_c.sig_in = 1'b0;
    cyc_a = 0; cyc_b = 0; cyc_c = 0;
    per_a = 0; ph_a = 0; per_b = 0; ph_b = 0; per_c = 0; ph_c = 0;
    last_busy = 1'b0;
    test_reset();
    test_period10();
    test_stuck_and_edge_at_t();
    test_reset_mid_shift();
    test_saturation();
    test_exact_9999();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
